// File: rtl/iomem_rr_arbiter.sv
// Two-master round-robin arbiter sharing one iomem slave; registers the slave request.
// Optional slave timeout enabled by defining IOMEM_ARB_TIMEOUT_EN.
module iomem_rr_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    output logic        grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("iomem_rr_arbiter: TIMEOUT_CYCLES out of range 1..65535");
    end

    state_t      state_q, state_d;
    logic        s_valid_q, s_valid_d;
    logic [3:0]  s_wstrb_q, s_wstrb_d;
    logic [31:0] s_addr_q, s_addr_d;
    logic [31:0] s_wdata_q, s_wdata_d;
    logic        m0_ready_q, m0_ready_d;
    logic        m1_ready_q, m1_ready_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;
    logic        grant_q, grant_d;
    // prio_q names the master that wins when both request.
    logic        prio_q, prio_d;
    logic        win;
    logic        done;
    logic [31:0] done_data;

`ifdef IOMEM_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        terr_q, terr_d;
`endif

    always_comb begin
        state_d    = state_q;
        s_valid_d  = s_valid_q;
        s_wstrb_d  = s_wstrb_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        m0_ready_d = m0_ready_q;
        m1_ready_d = m1_ready_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        grant_d    = grant_q;
        prio_d     = prio_q;
        win        = 1'b0;
        done       = 1'b0;
        done_data  = s_rdata;
`ifdef IOMEM_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        terr_d     = terr_q;
`endif
        case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    win       = (m0_valid && m1_valid) ? prio_q : m1_valid;
                    state_d   = REQ;
                    grant_d   = win;
                    prio_d    = ~win;
                    s_valid_d = 1'b1;
                    s_addr_d  = win ? m1_addr  : m0_addr;
                    s_wdata_d = win ? m1_wdata : m0_wdata;
                    s_wstrb_d = win ? m1_wstrb : m0_wstrb;
`ifdef IOMEM_ARB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            REQ: begin
                // s_ready takes precedence over a coincident timeout expiry.
                if (s_ready) begin
                    done = 1'b1;
                end
`ifdef IOMEM_ARB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    done      = 1'b1;
                    done_data = TIMEOUT_RDATA;
                    terr_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
                if (done) begin
                    s_valid_d = 1'b0;
                    state_d   = RESP;
                    if (grant_q) begin
                        m1_ready_d = 1'b1;
                        m1_rdata_d = done_data;
                    end else begin
                        m0_ready_d = 1'b1;
                        m0_rdata_d = done_data;
                    end
                end
            end
            RESP: begin
                m0_ready_d = 1'b0;
                m1_ready_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            s_valid_q  <= 1'b0;
            s_wstrb_q  <= '0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            grant_q    <= 1'b0;
            prio_q     <= 1'b0;
`ifdef IOMEM_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            terr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            s_valid_q  <= s_valid_d;
            s_wstrb_q  <= s_wstrb_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            m0_ready_q <= m0_ready_d;
            m1_ready_q <= m1_ready_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            grant_q    <= grant_d;
            prio_q     <= prio_d;
`ifdef IOMEM_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            terr_q     <= terr_d;
`endif
        end
    end

    assign s_valid  = s_valid_q;
    assign s_wstrb  = s_wstrb_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign m0_ready = m0_ready_q;
    assign m1_ready = m1_ready_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign grant    = grant_q;
`ifdef IOMEM_ARB_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_iomem_rr_arbiter.sv
// Bench for iomem_rr_arbiter: bench plays both masters and the slave, checking against a
// transaction-level model (arbitration rule, latched payload, returned data, sticky error).
module tb_iomem_rr_arbiter;

    localparam int unsigned TO = 8;
    localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;
`ifdef IOMEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m0_ready, m1_valid, m1_ready;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        s_valid, s_ready, grant, timeout_err;
    logic [31:0] s_addr, s_wdata, s_rdata;

    iomem_rr_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_RDATA(TO_DATA)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          prio;
    logic [31:0] mrd [2];
    bit          terr;
    bit          pend [2];
    logic [31:0] paddr [2];
    logic [31:0] pwdata [2];
    logic [3:0]  pwstrb [2];
    int          wcount [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_masters();
        m0_valid = pend[0]; m0_addr = paddr[0]; m0_wdata = pwdata[0]; m0_wstrb = pwstrb[0];
        m1_valid = pend[1]; m1_addr = paddr[1]; m1_wdata = pwdata[1]; m1_wstrb = pwstrb[1];
    endtask

    task automatic post(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        pend[m] = 1'b1; paddr[m] = a; pwdata[m] = d; pwstrb[m] = s;
    endtask

    task automatic post_rand(input int m);
        if (!pend[m]) post(m, $urandom, $urandom, 4'($urandom_range(0, 15)));
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_svalid"}, 32'(s_valid), 32'd0);
        chk({tag, "_rdy0"}, 32'(m0_ready), 32'd0);
        chk({tag, "_rdy1"}, 32'(m1_ready), 32'd0);
        chk({tag, "_rd0"}, m0_rdata, mrd[0]);
        chk({tag, "_rd1"}, m1_rdata, mrd[1]);
        chk({tag, "_terr"}, 32'(timeout_err), 32'(terr));
    endtask

    task automatic check_req(input string tag, input int w);
        chk({tag, "_svalid"}, 32'(s_valid), 32'd1);
        chk({tag, "_grant"}, 32'(grant), 32'(w));
        chk({tag, "_addr"}, s_addr, paddr[w]);
        chk({tag, "_wdata"}, s_wdata, pwdata[w]);
        chk({tag, "_wstrb"}, 32'(s_wstrb), 32'(pwstrb[w]));
        chk({tag, "_rdy0"}, 32'(m0_ready), 32'd0);
        chk({tag, "_rdy1"}, 32'(m1_ready), 32'd0);
    endtask

    // Starts at a negedge in IDLE with at least one request pending; returns at a negedge in IDLE.
    task automatic txn(input int delay, input logic [31:0] rd, input bit withdraw, output int w);
        bit          to_hit;
        int          n_low;
        logic [31:0] exp;
        drive_masters();
        w = (pend[0] && pend[1]) ? int'(prio) : (pend[1] ? 1 : 0);
        @(negedge clk);
        check_req("grant", w);
        prio = (w == 0);
        if (withdraw) begin
            pend[w] = 1'b0;
            drive_masters();
        end
        to_hit = TO_EN && (delay >= int'(TO));
        n_low  = to_hit ? int'(TO) : delay;
        for (int i = 0; i < n_low; i++) begin
            s_ready = 1'b0;
            s_rdata = $urandom;
            @(negedge clk);
            if (!(to_hit && i == n_low - 1)) check_req("hold", w);
        end
        if (!to_hit) begin
            s_ready = 1'b1;
            s_rdata = rd;
            @(negedge clk);
        end
        exp    = to_hit ? TO_DATA : rd;
        mrd[w] = exp;
        terr   = terr | to_hit;
        wcount[w]++;
        chk("resp_svalid", 32'(s_valid), 32'd0);
        chk("resp_rdy_win", 32'(w ? m1_ready : m0_ready), 32'd1);
        chk("resp_rdy_lose", 32'(w ? m0_ready : m1_ready), 32'd0);
        chk("resp_rd0", m0_rdata, mrd[0]);
        chk("resp_rd1", m1_rdata, mrd[1]);
        chk("resp_terr", 32'(timeout_err), 32'(terr));
        pend[w] = 1'b0;
        drive_masters();
        s_ready = 1'($urandom);
        s_rdata = $urandom;
        @(negedge clk);
        check_quiet("idle");
        chk("idle_grant", 32'(grant), 32'(w));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            s_ready = 1'($urandom);
            s_rdata = $urandom;
            @(negedge clk);
            check_quiet("noreq");
        end
    endtask

    // Called at a negedge; asserts reset, checks the asynchronous clear, releases.
    task automatic do_reset(input string tag);
        resetn = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        drive_masters();
        s_ready = 1'b0;
        prio = 1'b0; mrd[0] = '0; mrd[1] = '0; terr = 1'b0;
        #1;
        check_quiet(tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_saddr"}, s_addr, 32'd0);
        chk({tag, "_swdata"}, s_wdata, 32'd0);
        chk({tag, "_swstrb"}, 32'(s_wstrb), 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_quiet({tag, "_after"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, nreq;
        bit r0, r1;
        resetn = 1'b1;
        s_ready = 1'b0; s_rdata = '0;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 1'b0; paddr[m] = '0; pwdata[m] = '0; pwstrb[m] = '0; wcount[m] = 0;
        end
        drive_masters();
        @(negedge clk);
        do_reset("rst0");
        idle_cycles(3);

        // m0 read alone
        post(0, 32'h0300_0000, $urandom, 4'b0000);
        txn(3, 32'h1234_5678, 1'b0, w);
        chk("m0_read_winner", 32'(w), 32'd0);

        // Both masters, four requests each, back to back
        wcount[0] = 0; wcount[1] = 0;
        post_rand(0); post_rand(1);
        for (int i = 0; i < 8; i++) begin
            txn(1, $urandom, 1'b0, w);
            chk("alt_grant", 32'(w), 32'((i + 1) % 2));
            if (wcount[w] < 4) post_rand(w);
        end
        chk("alt_count0", 32'(wcount[0]), 32'd4);
        chk("alt_count1", 32'(wcount[1]), 32'd4);

        // m1 write, then m0 gets the next grant
        post(1, $urandom, 32'hAABB_CCDD, 4'b0101);
        txn(4, $urandom, 1'b0, w);
        chk("m1_write_winner", 32'(w), 32'd1);
        post_rand(0);
        txn(0, $urandom, 1'b0, w);
        chk("m0_after_m1", 32'(w), 32'd0);

        // Master withdraws valid mid-request: still completes
        post_rand(1);
        txn(2, $urandom, 1'b1, w);

        // Reset while m1 request is in flight
        post_rand(1);
        drive_masters();
        @(negedge clk);
        chk("midreq_svalid", 32'(s_valid), 32'd1);
        chk("midreq_grant", 32'(grant), 32'd1);
        do_reset("rst_mid");
        post_rand(0); post_rand(1);
        txn(0, $urandom, 1'b0, w);
        chk("prio_after_reset", 32'(w), 32'd0);
        txn(0, $urandom, 1'b0, w);

        // s_ready on the last allowed REQ cycle completes normally
        post_rand(0);
        txn(int'(TO) - 1, 32'h5555_AAAA, 1'b0, w);
        // s_ready never in time: timeout when enabled, long wait otherwise
        post_rand(0);
        txn(20, 32'h0BAD_F00D, 1'b0, w);
        post_rand(0);
        txn(1, $urandom, 1'b0, w);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            r0 = 1'($urandom); r1 = 1'($urandom);
            if (!r0 && !r1 && !pend[0] && !pend[1]) r0 = 1'b1;
            if (r0) post_rand(0);
            if (r1) post_rand(1);
            nreq = $urandom_range(0, 11);
            txn(nreq, $urandom, ($urandom_range(0, 9) == 0), w);
            if ($urandom_range(0, 3) == 0 && !pend[0] && !pend[1]) idle_cycles(1);
        end
        while (pend[0] || pend[1]) txn(0, $urandom, 1'b0, w);
        idle_cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
